// File: rtl/fcmp_pkg.sv
// Shared constants for the fcmp_sched compare scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: op encodings, FP32 field widths and the all-ones exponent.
package fcmp_pkg;

  // Compare op encoding carried on req_op
  localparam logic [1:0] OP_LE   = 2'b00;
  localparam logic [1:0] OP_LT   = 2'b01;
  localparam logic [1:0] OP_EQ   = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  // IEEE-754 single-precision field widths
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;

  // Exponent value shared by infinities and NaNs
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

endpackage

// File: rtl/fcmp_core.sv
// Combinational FP32 ordering: lt/eq relations plus NaN/sNaN detection.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the scheduler registers the result.
//
// Ports:
//   x1, x2 : FP32 operands
//   op     : compare op; the reserved encoding yields no relation (lt=eq=0)
//   lt     : x1 < x2 (0 if either operand is NaN, or +0/-0 pair)
//   eq     : x1 == x2 (+0 equals -0; 0 if either operand is NaN)
//   nan    : either operand is a NaN
//   snan   : either operand is a signalling NaN (quiet bit clear)
module fcmp_core
  import fcmp_pkg::*;
(
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic [1:0]  op,
  output logic        lt,
  output logic        eq,
  output logic        nan,
  output logic        snan
);

  logic              s1, s2;
  logic [EXP_W-1:0]  e1, e2;
  logic [MANT_W-1:0] m1, m2;
  logic [30:0]       mag1, mag2;
  logic              nan1, nan2, snan1, snan2;
  logic              both_zero;
  logic              ord_lt;
  logic              op_ok;

  assign s1   = x1[31];
  assign s2   = x2[31];
  assign e1   = x1[MANT_W +: EXP_W];
  assign e2   = x2[MANT_W +: EXP_W];
  assign m1   = x1[MANT_W-1:0];
  assign m2   = x2[MANT_W-1:0];
  assign mag1 = x1[30:0];
  assign mag2 = x2[30:0];

  assign nan1  = (e1 == EXP_ONES) && (m1 != '0);
  assign nan2  = (e2 == EXP_ONES) && (m2 != '0);
  // Quiet bit is the mantissa MSB; a NaN with it clear is signalling
  assign snan1 = nan1 && !m1[MANT_W-1];
  assign snan2 = nan2 && !m2[MANT_W-1];

  assign nan  = nan1 | nan2;
  assign snan = snan1 | snan2;

  assign both_zero = (mag1 == '0) && (mag2 == '0);

  // Sign-magnitude order: the magnitude bits sort like unsigned integers
  // (denormals and infinities included), reversed when both are negative.
  always_comb begin
    ord_lt = 1'b0;
    unique case ({s1, s2})
      2'b00:   ord_lt = (mag1 < mag2);
      2'b11:   ord_lt = (mag1 > mag2);
      2'b10:   ord_lt = 1'b1;
      default: ord_lt = 1'b0;
    endcase
  end

  assign op_ok = (op != OP_RSVD);

  assign lt = op_ok && !nan && !both_zero && ord_lt;
  assign eq = op_ok && !nan && (both_zero || (x1 == x2));

endmodule

// File: rtl/fcmp_sched.sv
// Round-robin scheduler sharing one FP32 compare unit among NREQ requesters.
// Latency: 1 cycle from accept (req_valid & req_ready) to rsp_valid.
// Backpressure: result held while rsp_ready=0; no grant until the slot frees.
//
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake, at most one ready bit set
//   req_x1, req_x2       : packed operands, requester i at [32i+31:32i]
//   req_op               : packed 2-bit ops (00 LE, 01 LT, 10 EQ, 11 reserved)
//   rsp_valid/rsp_ready  : result handshake
//   rsp_id, rsp_y        : owning requester and result (1 true / 0 false)
//   rsp_invalid          : invalid-operation flag, present only with FCMP_INVALID_EN
//
// Optional build macro: FCMP_INVALID_EN adds the rsp_invalid output.
module fcmp_sched
  import fcmp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_x1,
  input  logic [NREQ*32-1:0] req_x2,
  input  logic [NREQ*2-1:0]  req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]     rsp_id,
`ifdef FCMP_INVALID_EN
  output logic              rsp_invalid,
`endif
  output logic [31:0]        rsp_y
);

  logic [IDW-1:0] ptr;
  logic           slot_free;
  logic           found;
  logic           accept;
  logic [IDW-1:0] gidx;
  logic [31:0]    gx1, gx2;
  logic [1:0]     gop;
  logic           c_lt, c_eq, c_nan, c_snan;
  logic           ysel;

  assign slot_free = !rsp_valid || rsp_ready;

  // Scan from ptr+1 around the ring; the first valid requester wins.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    gx1   = '0;
    gx2   = '0;
    gop   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gidx  = IDW'(idx);
        gx1   = req_x1[32*idx +: 32];
        gx2   = req_x2[32*idx +: 32];
        gop   = req_op[2*idx +: 2];
      end
    end
  end

  // rstn gating keeps req_ready low while reset is asserted.
  assign accept = found && slot_free && rstn;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gidx] = 1'b1;
  end

  fcmp_core u_core (
    .x1   (gx1),
    .x2   (gx2),
    .op   (gop),
    .lt   (c_lt),
    .eq   (c_eq),
    .nan  (c_nan),
    .snan (c_snan)
  );

  // snan implies nan, so folding both in leaves the result unchanged; the
  // core already clears lt/eq on NaN, this is a second guard at the mux.
  always_comb begin
    ysel = 1'b0;
    unique case (gop)
      OP_LE:   ysel = c_lt | c_eq;
      OP_LT:   ysel = c_lt;
      OP_EQ:   ysel = c_eq;
      default: ysel = 1'b0;
    endcase
    if (c_nan || c_snan) ysel = 1'b0;
  end

  // State only moves when the slot is free: a stall freezes everything,
  // a drain without a new accept clears rsp_valid but holds id/y.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      ptr       <= IDW'(NREQ-1);
    end else if (slot_free) begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_id <= gidx;
        rsp_y  <= {31'd0, ysel};
        ptr    <= gidx;
      end
    end
  end

`ifdef FCMP_INVALID_EN
  // Signalling NaN is invalid for every op; any NaN is invalid for the
  // ordered relations LE and LT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_invalid <= 1'b0;
    end else if (slot_free && accept) begin
      rsp_invalid <= c_snan || (c_nan && (gop == OP_LE || gop == OP_LT));
    end
  end
`endif

endmodule

// File: tb/tb_fcmp_sched.sv
// Directed bench for fcmp_sched with a result scoreboard.
// Latency: expects each grant to surface on rsp one cycle later.
// Backpressure: drives rsp_ready low to stall and checks outputs hold.
module tb_fcmp_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rstn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_x1;
  logic [NREQ*32-1:0] req_x2;
  logic [NREQ*2-1:0]  req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_y;
`ifdef FCMP_INVALID_EN
  logic              rsp_invalid;
`endif

  fcmp_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
`ifdef FCMP_INVALID_EN
    .rsp_invalid (rsp_invalid),
`endif
    .rsp_y     (rsp_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    y;
    logic           inv;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] exp_y_tab [NREQ];
  logic        exp_inv_tab [NREQ];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Program requester i; the expected result is written alongside.
  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [31:0] y, input logic inv);
    req_x1[32*i +: 32] = a;
    req_x2[32*i +: 32] = b;
    req_op[2*i +: 2]   = op;
    exp_y_tab[i]       = y;
    exp_inv_tab[i]     = inv;
  endtask

  // Called at a falling edge after inputs for this cycle are applied.
  // Checks the held result against the scoreboard, then the grant.
  task automatic tick(input string tag, input logic [NREQ-1:0] exp_rdy);
    exp_t e;
    #1;
    chk({tag, ":rsp_valid"}, {31'd0, rsp_valid}, {31'd0, (exp_q.size() != 0)});
    if (rsp_valid && exp_q.size() != 0) begin
      e = exp_q[0];
      chk({tag, ":rsp_id"}, {30'd0, rsp_id}, {30'd0, e.id});
      chk({tag, ":rsp_y"}, rsp_y, e.y);
`ifdef FCMP_INVALID_EN
      chk({tag, ":rsp_invalid"}, {31'd0, rsp_invalid}, {31'd0, e.inv});
`endif
      if (rsp_ready) void'(exp_q.pop_front());
    end
    chk({tag, ":req_ready"}, {28'd0, req_ready}, {28'd0, exp_rdy});
    for (int i = 0; i < NREQ; i++) begin
      if (exp_rdy[i]) begin
        e.id  = IDW'(i);
        e.y   = exp_y_tab[i];
        e.inv = exp_inv_tab[i];
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rstn      = 1'b0;
    req_valid = '1;
    req_x1    = '0;
    req_x2    = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      exp_y_tab[i]   = '0;
      exp_inv_tab[i] = 1'b0;
    end

    // Reset state, with every requester asking
    @(negedge clk);
    #1;
    chk("rst:rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst:rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("rst:rsp_y", rsp_y, 32'd0);
    chk("rst:req_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    req_valid = '0;
    rstn      = 1'b1;

    // Single request: 1.0 LE 2.0 then 1.0 EQ 2.0
    set_req(0, 32'h3F800000, 32'h40000000, 2'b00, 32'd1, 1'b0);
    req_valid = 4'b0001;
    tick("single_le", 4'b0001);
    req_valid = 4'b0000;
    tick("single_le_rsp", 4'b0000);
    set_req(0, 32'h3F800000, 32'h40000000, 2'b10, 32'd0, 1'b0);
    req_valid = 4'b0001;
    tick("single_eq", 4'b0001);
    req_valid = 4'b0000;
    tick("single_eq_rsp", 4'b0000);

    // Special values, round-robin from pointer 0: grants 1,2,3,0,1,2,3,0
    set_req(0, 32'h80000000, 32'h00000000, 2'b01, 32'd0, 1'b0); // -0 LT +0
    set_req(1, 32'h80000000, 32'h00000000, 2'b10, 32'd1, 1'b0); // -0 EQ +0
    set_req(2, 32'hBF800000, 32'hC0000000, 2'b00, 32'd0, 1'b0); // -1 LE -2
    set_req(3, 32'h7FC00000, 32'h3F800000, 2'b10, 32'd0, 1'b0); // qNaN EQ
    req_valid = 4'b1111;
    tick("rr_a1", 4'b0010);
    tick("rr_a2", 4'b0100);
    tick("rr_a3", 4'b1000);
    tick("rr_a0", 4'b0001);
    tick("rr_b1", 4'b0010);
    tick("rr_b2", 4'b0100);
    tick("rr_b3", 4'b1000);
    tick("rr_b0", 4'b0001);

    set_req(0, 32'h7FC00000, 32'h00000000, 2'b01, 32'd0, 1'b1); // qNaN LT
    set_req(1, 32'h7F800001, 32'h00000000, 2'b10, 32'd0, 1'b1); // sNaN EQ
    set_req(2, 32'hFF800000, 32'hFF7FFFFF, 2'b01, 32'd1, 1'b0); // -inf LT -max
    set_req(3, 32'h00000001, 32'h00000002, 2'b01, 32'd1, 1'b0); // denormals
    tick("sp_1", 4'b0010);
    tick("sp_2", 4'b0100);
    tick("sp_3", 4'b1000);
    tick("sp_0", 4'b0001);

    // Backpressure: reserved op on r1, mixed signs on r3/r0
    set_req(1, 32'h3F800000, 32'h40000000, 2'b11, 32'd0, 1'b0); // reserved
    set_req(3, 32'h3F800000, 32'hBF800000, 2'b00, 32'd0, 1'b0); // +1 LE -1
    set_req(0, 32'hBF800000, 32'h3F800000, 2'b01, 32'd1, 1'b0); // -1 LT +1
    tick("bp_grant1", 4'b0010);
    rsp_ready = 1'b0;
    tick("bp_stall_a", 4'b0000);
    tick("bp_stall_b", 4'b0000);
    tick("bp_stall_c", 4'b0000);
    rsp_ready = 1'b1;
    tick("bp_release", 4'b0100);
    tick("bp_next3", 4'b1000);
    tick("bp_next0", 4'b0001);

    // Reset mid-stream while a result is held and requests are pending
    rstn = 1'b0;
    #1;
    chk("midrst:rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst:rsp_y", rsp_y, 32'd0);
    chk("midrst:req_ready", {28'd0, req_ready}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rstn      = 1'b1;
    req_valid = 4'b0110;
    tick("post_rst_grant", 4'b0010);
    req_valid = 4'b0000;
    tick("post_rst_rsp", 4'b0000);
    tick("idle", 4'b0000);
    chk("final:queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fcmp_sched.md
Name: fcmp_sched

Overview:
- Shares one IEEE-754 single-precision compare unit among NREQ requesters.
- Round-robin arbiter feeding a registered compare stage; one result per cycle with valid/ready backpressure.
- Sits between the FPU issue ports and the compare datapath, so every requester gets LE/LT/EQ without its own comparator.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester index; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit set per cycle.
- req_x1  in  NREQ*32  operand 1 per requester (requester i at bits [32i+31:32i]).
- req_x2  in  NREQ*32  operand 2 per requester.
- req_op  in  NREQ*2  op per requester: 00 LE, 01 LT, 10 EQ, 11 reserved.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_y  out  32  result, 32'd1 true / 32'd0 false.

Behaviour:
- Reset (async on rstn low): rsp_valid=0, rsp_id=0, rsp_y=0, req_ready=0, RR pointer=NREQ-1, so requester 0 has top priority first.
- Slot free when rsp_valid=0 or (rsp_valid & rsp_ready); no request is accepted unless the slot is free.
- Arbitration (combinational): scan from pointer+1 modulo NREQ; the first requester with req_valid set gets req_ready=1 when the slot is free.
- req_ready never depends on the requester's own valid in a way that creates a loop. It is a function of all req_valid, pointer and slot state.
- Accept (req_valid[i] & req_ready[i]):
  - Next edge: rsp_valid=1, rsp_id=i, rsp_y=compare result; pointer=i.
- Latency: exactly 1 cycle from accept to rsp_valid.
- Throughput: 1 per cycle while rsp_ready=1.
- Drain without new accept: rsp_valid=0; rsp_id and rsp_y hold their values.
- Stall (rsp_valid & ~rsp_ready): all outputs hold; req_ready=0; pointer holds.
- Pointer updates only on accept. Idle cycles and stalls do not rotate priority.
- Compare semantics:
  - Any NaN operand (exp=255, mant!=0) gives 0 for every op, including EQ.
  - +0 and -0 are equal: LE=1, LT=0, EQ=1.
  - Otherwise ordered by value, with infinities ordered normally and denormals compared exactly (no flush).
  - Reserved op 11 gives 0.
- Ordering rule:
  - Both non-negative: unsigned compare of the magnitude bits.
  - Both negative: the order is reversed.
  - Mixed signs: the negative operand is smaller, except the ±0 case.
- Reset mid-operation discards any pending result; requesters must re-issue.

Optional Feature:
- Macro FCMP_INVALID_EN.
- Defined:
  - Adds output rsp_invalid (1 bit), registered alongside rsp_y, reset 0.
  - Set when either operand is a signalling NaN (exp=255, mant!=0, mant[22]=0) for any op.
  - Set for any NaN operand when op is LE or LT.
- Undefined: port absent, no logic; behaviour otherwise identical.

Decomposition:
- Package fcmp_pkg:
  - op encoding constants (OP_LE, OP_LT, OP_EQ, OP_RSVD).
  - FP32 field widths (EXP_W=8, MANT_W=23).
  - Exponent all-ones constant.
- Sub-module fcmp_core: purely combinational, inputs x1, x2, op; outputs lt, eq, nan, snan. Instantiated once; the scheduler selects its final bit from op.

Test Plan:
- Single request: requester 0, x1=0x3F800000 (1.0), x2=0x40000000 (2.0), op LE.
  - Required: req_ready[0]=1 in that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_y=1. Same with op EQ gives rsp_y=0.
- Round-robin: all 4 requesters valid continuously, rsp_ready=1.
  - Required: grants in order 0,1,2,3,0,…; one rsp per cycle with rsp_id following the same sequence.
- Backpressure: rsp_ready=0 for 3 cycles after a result.
  - Required: rsp_valid, rsp_id and rsp_y stable; all req_ready=0; pointer unchanged.
  - Then rsp_ready=1: the pending result drains and the next accept happens the same cycle.
- Special values:
  - x1=0x80000000 (-0), x2=0x00000000, op EQ → y=1; op LT → y=0.
  - x1=0xBF800000 (-1.0), x2=0xC0000000 (-2.0), op LE → y=0.
  - x1=0x7FC00000 (qNaN), op EQ → y=0. With FCMP_INVALID_EN, op LT sets rsp_invalid=1.
- Reset mid-stream: assert rstn=0 while rsp_valid=1 and a request is pending.
  - Required: rsp_valid=0 immediately (async).
  - After release, the first grant goes to the lowest-indexed valid requester starting from 0.
